// File: rtl/fmul_stream.sv
// fmul_stream: two-stage valid/ready wrapper around a combinational IEEE-754 FP32 multiplier.
// Define FMUL_STREAM_FLAGS_EN to enable exception classification, out_flags and sticky_flags.
module fmul_stream #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [3:0]       out_flags,
   output logic [3:0]       sticky_flags,
   input  logic             clr_flags,
   output logic [CNT_W-1:0] result_cnt
);

   // Round-to-nearest-even product with subnormal support; every NaN result is 0x7FC00000.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic               s;
      logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [7:0]         ea, eb;
      logic [23:0]        ma, mb;
      logic [47:0]        prod, norm;
      logic [5:0]         lz, sh;
      logic signed [10:0] e_sum;
      logic [95:0]        wide;
      logic [23:0]        sig;
      logic               g, st, inc;
      logic [30:0]        base_val, mag;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      ea     = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
      eb     = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
      ma     = {a[30:23] != 8'd0, a[22:0]};
      mb     = {b[30:23] != 8'd0, b[22:0]};
      prod   = 48'(ma) * 48'(mb);
      lz     = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (prod[i]) lz = 6'(47 - i);
      end
      norm  = prod << lz;
      e_sum = 11'(ea) + 11'(eb) - 11'(lz) - 11'd126;
      // Results below the normal range are denormalised before rounding so the
      // rounding carry can still promote them into the smallest normal.
      if (e_sum < 11'sd1) begin
         sh       = (e_sum < -11'sd48) ? 6'd50 : 6'(11'sd1 - e_sum);
         base_val = 31'd0;
      end else begin
         sh       = 6'd0;
         base_val = {e_sum[7:0] - 8'd1, 23'd0};
      end
      wide = {norm, 48'd0} >> sh;
      sig  = wide[95:72];
      g    = wide[71];
      st   = |wide[70:0];
      inc  = g & (st | sig[0]);
      mag  = base_val + {7'd0, sig} + {30'd0, inc};
      if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) return 32'h7FC0_0000;
      else if (a_inf | b_inf) return {s, 8'hFF, 23'd0};
      else if (a_zero | b_zero) return {s, 31'd0};
      else if (e_sum > 11'sd254) return {s, 8'hFF, 23'd0};
      else return {s, mag};
   endfunction

   logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d, prod;
   logic             v1_q, v1_d, v2_q, v2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             adv1, adv2, accept;

   always_comb begin
      adv2     = v2_q & out_ready;
      adv1     = v1_q & (~v2_q | out_ready);
      in_ready = ~v1_q | ~v2_q | out_ready;
      accept   = in_valid & in_ready;
      prod     = fmul(a_q, b_q);
      a_d      = accept ? in_a : a_q;
      b_d      = accept ? in_b : b_q;
      v1_d     = accept | (v1_q & ~adv1);
      v2_d     = adv1 | (v2_q & ~adv2);
      res_d    = adv1 ? prod : res_q;
      cnt_d    = adv2 ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         v1_q  <= 1'b0;
         res_q <= '0;
         v2_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         v1_q  <= v1_d;
         res_q <= res_d;
         v2_q  <= v2_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid  = v2_q;
   assign out_data   = res_q;
   assign result_cnt = cnt_q;

`ifdef FMUL_STREAM_FLAGS_EN
   logic [3:0] flg_q, flg_d, sticky_q, sticky_d;
   logic       nan_in, a_inf, b_inf, a_zero, b_zero, invalid, is_inf, is_zero;

   always_comb begin
      nan_in  = ((a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0)) ||
                ((b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0));
      a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
      a_zero  = (a_q[30:0] == 31'd0);
      b_zero  = (b_q[30:0] == 31'd0);
      invalid = ~nan_in & ((a_inf & b_zero) | (a_zero & b_inf));
      is_inf  = (prod[30:23] == 8'hFF) && (prod[22:0] == 23'd0);
      is_zero = (prod[30:0] == 31'd0);
      flg_d   = adv1 ? {invalid, nan_in, is_inf, is_zero} : flg_q;
      // A clear wipes history only; a result handed off in the same cycle still lands.
      sticky_d = clr_flags ? 4'd0 : sticky_q;
      if (adv2) sticky_d = sticky_d | flg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flg_q    <= '0;
         sticky_q <= '0;
      end else begin
         flg_q    <= flg_d;
         sticky_q <= sticky_d;
      end
   end

   assign out_flags    = flg_q;
   assign sticky_flags = sticky_q;
`else
   logic flags_unused;
   assign flags_unused = clr_flags;
   assign out_flags    = 4'd0;
   assign sticky_flags = 4'd0;
`endif

endmodule
